// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
//   Bundles the request, hopper and status signals of the change dispenser.
//   master : vending controller / hopper side (drives request, empty flags, ack)
//   slave  : change_dispenser itself
//
//   start      1  one-cycle change request
//   amount     7  change to pay, unsigned
//   empty      4  hopper empty flags (bit0=1, bit1=2, bit2=10, bit3=20)
//   coin_ack   1  hopper drop sensor
//   eject      1  coin release pulse
//   eject_sel  2  denomination code (00=1, 01=2, 10=10, 11=20)
//   busy       1  payout in progress
//   done       1  one-cycle completion pulse
//   fault      1  sticky, change could not be completed
//   remaining  7  amount still owed
//   dispensed  7  amount paid in the current transaction
// -----------------------------------------------------------------------------
interface change_dispenser_if;
  logic       start;
  logic [6:0] amount;
  logic [3:0] empty;
  logic       coin_ack;
  logic       eject;
  logic [1:0] eject_sel;
  logic       busy;
  logic       done;
  logic       fault;
  logic [6:0] remaining;
  logic [6:0] dispensed;

  modport master (
    output start, amount, empty, coin_ack,
    input  eject, eject_sel, busy, done, fault, remaining, dispensed
  );

  modport slave (
    input  start, amount, empty, coin_ack,
    output eject, eject_sel, busy, done, fault, remaining, dispensed
  );
endinterface

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//   Pays out a change amount through the coin hopper, largest available
//   denomination first (20, 10, 2, 1). Each coin is an eject pulse answered by
//   a rising edge on the hopper drop sensor, guarded by a timeout.
//
//   Parameters
//     PULSE_LEN  cycles eject is held high per coin (>=1)
//     TIMEOUT    cycles from eject rise without ack before a jam (> PULSE_LEN)
//
//   Ports
//     CLK   clock, rising edge
//     RST   asynchronous active-low reset
//     bus   change_dispenser_if.slave (request, hopper handshake, status)
//
//   Optional feature
//     CHANGE_JAM_FALLBACK_EN  defined: a timed-out denomination is masked as
//                             jammed and payout falls back to smaller coins.
//                             undefined: a timeout goes straight to FAULT.
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 255
) (
  input logic               CLK,
  input logic               RST,
  change_dispenser_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_PULSE    = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [6:0]    rem_q, rem_d;
  logic [6:0]    disp_q, disp_d;
  logic [1:0]    sel_q, sel_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          eject_q, eject_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic          ack_prev_q;

  logic [3:0]    jam_mask;
  logic [3:0]    avail;
  logic          pick_ok;
  logic [1:0]    pick_sel;
  logic [6:0]    sel_val;
  logic          ack_rise;

  function automatic logic [6:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   return 7'd1;
      2'b01:   return 7'd2;
      2'b10:   return 7'd10;
      default: return 7'd20;
    endcase
  endfunction

`ifdef CHANGE_JAM_FALLBACK_EN
  logic [3:0] jam_q, jam_d;
  assign jam_mask = jam_q;
`else
  assign jam_mask = 4'b0000;
`endif

  // A denomination qualifies when it is stocked, not jammed and fits the
  // amount still owed, so the subtraction below can never underflow.
  for (genvar gi = 0; gi < 4; gi++) begin : g_avail
    assign avail[gi] = !bus.empty[gi] && !jam_mask[gi] && (rem_q >= coin_value(2'(gi)));
  end

  always_comb begin
    pick_ok  = 1'b1;
    pick_sel = 2'b00;
    if (avail[3])      pick_sel = 2'b11;
    else if (avail[2]) pick_sel = 2'b10;
    else if (avail[1]) pick_sel = 2'b01;
    else if (avail[0]) pick_sel = 2'b00;
    else               pick_ok  = 1'b0;
  end

  assign sel_val  = coin_value(sel_q);
  // Only the rising edge counts, so an ack held across cycles is one coin.
  assign ack_rise = bus.coin_ack && !ack_prev_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    disp_d  = disp_q;
    sel_d   = sel_q;
    tmr_d   = tmr_q;
    eject_d = eject_q;
`ifdef CHANGE_JAM_FALLBACK_EN
    jam_d   = jam_q;
`endif
    case (state_q)
      S_IDLE, S_FAULT: begin
        if (bus.start) begin
          rem_d   = bus.amount;
          disp_d  = 7'd0;
`ifdef CHANGE_JAM_FALLBACK_EN
          jam_d   = 4'b0000;
`endif
          state_d = (bus.amount == 7'd0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 7'd0) begin
          state_d = S_DONE;
        end else if (pick_ok) begin
          sel_d   = pick_sel;
          tmr_d   = '0;
          eject_d = 1'b1;
          state_d = S_PULSE;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_PULSE, S_WAIT_ACK: begin
        tmr_d = tmr_q + 1'b1;
        // Ack has priority over both the end of the pulse and the timeout.
        if (ack_rise) begin
          rem_d   = rem_q - sel_val;
          disp_d  = disp_q + sel_val;
          eject_d = 1'b0;
          state_d = S_SELECT;
        end else if (state_q == S_WAIT_ACK && tmr_q == TW'(TIMEOUT - 1)) begin
`ifdef CHANGE_JAM_FALLBACK_EN
          jam_d[sel_q] = 1'b1;
          state_d      = S_SELECT;
`else
          state_d      = S_FAULT;
`endif
        end else if (state_q == S_PULSE && tmr_q == TW'(PULSE_LEN - 1)) begin
          eject_d = 1'b0;
          state_d = S_WAIT_ACK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A zero-amount request goes IDLE -> DONE without ever raising busy;
  // DONE entered from a real payout keeps busy high through the done pulse.
  assign busy_d  = (state_d == S_SELECT) || (state_d == S_PULSE) || (state_d == S_WAIT_ACK) ||
                   ((state_d == S_DONE) && (state_q == S_SELECT));
  assign done_d  = (state_d == S_DONE);
  assign fault_d = (state_d == S_FAULT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      rem_q      <= 7'd0;
      disp_q     <= 7'd0;
      sel_q      <= 2'b00;
      tmr_q      <= '0;
      eject_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      ack_prev_q <= 1'b0;
`ifdef CHANGE_JAM_FALLBACK_EN
      jam_q      <= 4'b0000;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      disp_q     <= disp_d;
      sel_q      <= sel_d;
      tmr_q      <= tmr_d;
      eject_q    <= eject_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      ack_prev_q <= bus.coin_ack;
`ifdef CHANGE_JAM_FALLBACK_EN
      jam_q      <= jam_d;
`endif
    end
  end

  assign bus.eject     = eject_q;
  assign bus.eject_sel = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.remaining = rem_q;
  assign bus.dispensed = disp_q;
endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//   Directed bench for change_dispenser. A small hopper model answers each
//   eject rise with coin_ack after a programmable delay and hold length, and
//   can refuse one denomination to emulate a jam. A monitor logs the code of
//   every eject rise and counts done pulses.
// -----------------------------------------------------------------------------
module tb_change_dispenser;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  change_dispenser_if bus ();

  change_dispenser #(.PULSE_LEN(4), .TIMEOUT(255)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hopper model
  int         ack_delay = 3;
  int         ack_len   = 1;
  bit         jam_en    = 1'b0;
  logic [1:0] jam_sel   = 2'b00;
  int         hop_cnt   = -1;
  int         hop_hold  = 0;
  logic       hop_prev  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hop_cnt      = -1;
      hop_hold     = 0;
      hop_prev     = 1'b0;
      bus.coin_ack = 1'b0;
    end else begin
      if (hop_hold > 0) begin
        hop_hold--;
        if (hop_hold == 0) bus.coin_ack = 1'b0;
      end
      if (hop_cnt > 0) begin
        hop_cnt--;
      end else if (hop_cnt == 0) begin
        bus.coin_ack = 1'b1;
        hop_hold     = ack_len;
        hop_cnt      = -1;
      end
      if (bus.eject && !hop_prev && !(jam_en && bus.eject_sel == jam_sel))
        hop_cnt = ack_delay - 1;
      hop_prev = bus.eject;
    end
  end

  // Monitor
  logic [31:0] sel_hist = '0;
  int          n_ej     = 0;
  int          done_cnt = 0;
  logic        mon_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
    end else begin
      if (bus.eject && !mon_prev) begin
        sel_hist = {sel_hist[29:0], bus.eject_sel};
        n_ej++;
      end
      if (bus.done) done_cnt++;
      mon_prev = bus.eject;
    end
  end

  task automatic run_tx(input logic [6:0] amt, input logic [3:0] emp);
    sel_hist   = '0;
    n_ej       = 0;
    done_cnt   = 0;
    bus.empty  = emp;
    bus.amount = amt;
    bus.start  = 1'b1;
    tick(1);
    bus.start  = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(bus.done || bus.fault) && n < 2000) begin
      tick(1);
      n++;
    end
    check({tag, "_bound"}, (n < 2000) ? 1 : 0, 1);
    tick(1);
    $display("tx %s: coins=%0d hist=%h remaining=%0d dispensed=%0d fault=%0d dones=%0d",
             tag, n_ej, sel_hist, bus.remaining, bus.dispensed, bus.fault, done_cnt);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.amount = 7'd0;
    bus.empty  = 4'b0000;

    // Reset state
    tick(3);
    check("rst_eject", bus.eject, 0);
    check("rst_sel", bus.eject_sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_remaining", bus.remaining, 0);
    check("rst_dispensed", bus.dispensed, 0);
    rst_n = 1'b1;
    tick(2);

    // Full payout 33 = 20 + 10 + 2 + 1, with an ignored start mid-coin
    run_tx(7'd33, 4'b0000);
    check("t1_busy_n1", bus.busy, 1);
    check("t1_eject_n1", bus.eject, 0);
    tick(1);
    check("t1_eject_n2", bus.eject, 1);
    check("t1_sel_n2", bus.eject_sel, 3);
    tick(2);
    bus.amount = 7'd99;
    bus.start  = 1'b1;
    tick(1);
    bus.start  = 1'b0;
    wait_end("t1_full");
    check("t1_hist", int'(sel_hist), 32'h000000E4);
    check("t1_coins", n_ej, 4);
    check("t1_dispensed", bus.dispensed, 33);
    check("t1_remaining", bus.remaining, 0);
    check("t1_dones", done_cnt, 1);
    check("t1_fault", bus.fault, 0);
    check("t1_busy_end", bus.busy, 0);

    // Zero amount
    run_tx(7'd0, 4'b0000);
    check("t2_done_n1", bus.done, 1);
    check("t2_busy_n1", bus.busy, 0);
    tick(1);
    check("t2_done_n2", bus.done, 0);
    check("t2_busy_n2", bus.busy, 0);
    check("t2_coins", n_ej, 0);
    $display("tx t2_zero: coins=%0d dones=%0d", n_ej, done_cnt);

    // Empty 20s: 45 = 4x10 + 2x2 + 1
    run_tx(7'd45, 4'b1000);
    wait_end("t3_fallback");
    check("t3_hist", int'(sel_hist), 32'h00002A94);
    check("t3_coins", n_ej, 7);
    check("t3_dispensed", bus.dispensed, 45);
    check("t3_remaining", bus.remaining, 0);

    // Unpayable remainder, then a new start clears the fault
    run_tx(7'd5, 4'b0001);
    wait_end("t4_unpayable");
    check("t4_fault", bus.fault, 1);
    check("t4_busy", bus.busy, 0);
    check("t4_remaining", bus.remaining, 1);
    check("t4_dispensed", bus.dispensed, 4);
    check("t4_hist", int'(sel_hist), 32'h00000005);
    tick(5);
    check("t4_fault_sticky", bus.fault, 1);
    run_tx(7'd3, 4'b0000);
    check("t4_fault_clear", bus.fault, 0);
    wait_end("t4_retry");
    check("t4_retry_hist", int'(sel_hist), 32'h00000004);
    check("t4_retry_dispensed", bus.dispensed, 3);
    check("t4_retry_dones", done_cnt, 1);

    // Ack held high for 10 cycles counts as one coin
    ack_delay = 12;
    ack_len   = 10;
    run_tx(7'd3, 4'b0010);
    tick(21);
    check("t5_remaining_mid", bus.remaining, 2);
    wait_end("t5_hold");
    check("t5_coins", n_ej, 3);
    check("t5_dispensed", bus.dispensed, 3);
    check("t5_dones", done_cnt, 1);
    ack_delay = 3;
    ack_len   = 1;

    // Jam on the 10
    jam_en  = 1'b1;
    jam_sel = 2'b10;
    run_tx(7'd12, 4'b0000);
    wait_end("t6_jam");
`ifdef CHANGE_JAM_FALLBACK_EN
    check("t6_hist", int'(sel_hist), 32'h00002555);
    check("t6_coins", n_ej, 7);
    check("t6_dispensed", bus.dispensed, 12);
    check("t6_remaining", bus.remaining, 0);
    check("t6_fault", bus.fault, 0);
    check("t6_dones", done_cnt, 1);
`else
    check("t6_fault", bus.fault, 1);
    check("t6_remaining", bus.remaining, 12);
    check("t6_dispensed", bus.dispensed, 0);
    check("t6_coins", n_ej, 1);
`endif
    // Jam mask cleared by the next start: the 10 is usable again
    jam_en = 1'b0;
    run_tx(7'd10, 4'b0000);
    wait_end("t6_after_jam");
    check("t6b_hist", int'(sel_hist), 32'h00000002);
    check("t6b_dispensed", bus.dispensed, 10);
    check("t6b_fault", bus.fault, 0);

    // Reset while waiting for ack
    jam_en  = 1'b1;
    jam_sel = 2'b11;
    run_tx(7'd20, 4'b0000);
    tick(8);
    check("t7_busy_pre", bus.busy, 1);
    check("t7_eject_pre", bus.eject, 0);
    check("t7_sel_pre", bus.eject_sel, 3);
    rst_n = 1'b0;
    #1;
    check("t7_eject", bus.eject, 0);
    check("t7_sel", bus.eject_sel, 0);
    check("t7_busy", bus.busy, 0);
    check("t7_done", bus.done, 0);
    check("t7_fault", bus.fault, 0);
    check("t7_remaining", bus.remaining, 0);
    check("t7_dispensed", bus.dispensed, 0);
    $display("tx t7_reset_wait: busy=%0d remaining=%0d", bus.busy, bus.remaining);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Reset mid-pulse drops eject without a clock edge
    run_tx(7'd20, 4'b0000);
    tick(1);
    check("t8_eject_pre", bus.eject, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_eject_async", bus.eject, 0);
    check("t8_remaining", bus.remaining, 0);
    $display("tx t8_reset_pulse: eject=%0d", bus.eject);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("t8_busy_after", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-return engine for the vending machine. After a sale, the controller hands it the change amount (A − cost). It pays that amount out through the coin hopper, using the largest available denomination first from the machine's coin set of 20, 10, 2 and 1. Each coin is ejected with a pulse/acknowledge handshake against the hopper's drop sensor, with a timeout. This block is the output-side counterpart to the coin-accumulation datapath.

## Interface
Parameters:
- PULSE_LEN, 4, cycles `eject` is held high per coin (≥1)
- TIMEOUT, 255, cycles from `eject` rise without `coin_ack` before the coin is declared jammed (> PULSE_LEN)

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- amount  in  7  change to pay, unsigned, 0..127
- empty  in  4  per-denomination hopper empty flags; bit0=1, bit1=2, bit2=10, bit3=20
- coin_ack  in  1  hopper drop sensor, synchronous to CLK, one or more cycles high per coin
- eject  out  1  coin release pulse
- eject_sel  out  2  denomination code: 00=1, 01=2, 10=10, 11=20 (same encoding as the coin-add select)
- busy  out  1  high outside IDLE/FAULT
- done  out  1  one-cycle pulse when the full amount has been paid
- fault  out  1  sticky; change could not be completed
- remaining  out  7  amount still owed
- dispensed  out  7  amount paid in the current transaction

## Operation
- States: IDLE, SELECT, PULSE, WAIT_ACK, DONE, FAULT.
- **IDLE**
  - `start` with amount≠0: load remaining=amount, dispensed=0, clear jam mask, go to SELECT.
  - `start` with amount=0: go to DONE.
- **SELECT**
  - remaining=0: go to DONE.
  - Otherwise pick the largest d in {20,10,2,1} with d≤remaining, `empty`[d]=0 and d not jammed.
  - Then register `eject_sel`, clear the timeout counter and go to PULSE.
  - If no denomination qualifies: go to FAULT.
- **PULSE**
  - `eject`=1 for PULSE_LEN cycles, then go to WAIT_ACK with `eject`=0.
- **Accepting `coin_ack`**
  - `coin_ack` is accepted in PULSE or WAIT_ACK, on its rising edge only (a level held high counts as one coin).
  - On acceptance: remaining −= d, dispensed += d, `eject` drops next cycle, go to SELECT.
- **Timeout**
  - The counter runs from the first PULSE cycle.
  - Reaching TIMEOUT with no ack is handled as set out under Configuration.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **FAULT**
  - `fault`=1 and `busy`=0.
  - `remaining` and `dispensed` are held for readout.
  - A new `start` clears `fault` and is processed as it would be from IDLE.
- **Ignored inputs**
  - `start` is ignored while busy.
  - `coin_ack` is ignored in IDLE, SELECT, DONE and FAULT.
- **Arithmetic**
  - 7-bit unsigned.
  - Selection guarantees d≤remaining, so subtraction never underflows.
  - dispensed never exceeds amount.
- **Empty flags**
  - `empty` is evaluated only in SELECT.
  - A flag changing mid-coin does not abort that coin.

## Timing
- All outputs are registered.
- Reset values: `eject`=0, `eject_sel`=00, `busy`=0, `done`=0, `fault`=0, `remaining`=0, `dispensed`=0, state=IDLE.
- **Start latency**
  - `start` sampled at edge N: SELECT during N+1, `eject` high from N+2.
  - amount=0: `done` high in cycle N+1 and `busy` never rises.
- **Per-coin latency**
  - An ack sampled at edge M updates remaining/dispensed at M+1.
  - The next `eject` rises at M+2.
- **Last coin**
  - After the last coin's ack, SELECT sees remaining=0.
  - `done` pulses 2 cycles after the ack edge.
- **Collisions**
  - Ack and timeout in the same cycle: ack wins.
- **Reset**
  - Reset asserted at any time, including mid-PULSE, forces the reset values immediately.
  - `eject` falls asynchronously.

## Configuration
- Macro: `CHANGE_JAM_FALLBACK_EN`.
- **Defined**
  - A timeout sets the jam bit for the current denomination (cleared on the next accepted `start`).
  - The block then returns to SELECT, so payment falls back to smaller coins.
  - FAULT is entered only when no denomination qualifies.
- **Undefined**
  - A timeout goes straight to FAULT.
  - There is no jam mask logic.

## Test plan
- **Full payout:** amount=33, empty=0000, ack 3 cycles after each eject rise → sel sequence 11,10,01,00; dispensed=33; remaining=0; one `done`; `fault`=0.
- **Zero amount:** amount=0 → `done` in cycle N+1; no `eject`; `busy` stays 0.
- **Empty fallback:** amount=45, empty=1000 → four 10s, two 2s, one 1; dispensed=45.
- **Unpayable remainder:** amount=5, empty=0001 → two 2s, then FAULT with remaining=1, dispensed=4; a new `start` with amount=3 clears `fault` and pays 2+1.
- **Jam on a 10:** amount=12, no ack for the 10 until timeout.
  - Macro defined: sel 10 times out, then 01, 01, 01, 01, 01, 01 (six 2s), `done`.
  - Macro undefined: FAULT with remaining=12 at TIMEOUT.
- **Mid-operation disturbances:**
  - Reset in WAIT_ACK → all outputs at reset values.
  - `start` while busy is ignored.
  - `coin_ack` held high for 10 cycles counts as one coin.
